// File: rtl/step_state_register.sv
// step_state_register: sequential wrapper around the NextStateLogic block.
// Synchronizes and debounces the Step push-button and the direction switches,
// presents the current state and latched direction to NextStateLogic, and
// registers the returned next state once per accepted press. Also keeps a
// saturating step counter and a sticky out-of-range error flag.
// Optional feature macro: STEP_SEVEN_SEG_EN adds a registered 7-segment
// decode of the current state on output Seg.
//
// Handshake note: there is no valid/ready pair here; the only "transaction"
// is an accepted button press. Next_S is sampled only in the single APPLY
// cycle, when Cur_S and Cur_A are stable, so the combinational loop through
// NextStateLogic is settled at that edge.
module step_state_register #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Step_btn,
   input  logic [1:0] Sw,
   input  logic [3:0] Next_S,
   output logic [3:0] Cur_S,
   output logic [1:0] Cur_A,
   output logic       Busy,
   output logic [7:0] Step_count,
   output logic       Err
`ifdef STEP_SEVEN_SEG_EN
   ,
   output logic [6:0] Seg
`endif
);

   // Last debounce count value; reaching it with the input still stable
   // completes the debounce window.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]       S_MAX    = 4'd8;
   localparam logic [7:0]       CNT_SAT  = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_APPLY    = 2'd2,
      ST_WAIT_REL = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       cur_s_q, cur_s_d;
   logic [1:0]       cur_a_q, cur_a_d;
   logic [7:0]       steps_q, steps_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   // Two-flop synchronizers; index 1 is the stage the FSM consumes.
   logic [1:0]       stp_sync_q;
   logic [1:0]       sw_sync1_q;
   logic [1:0]       sw_sync2_q;
   logic             stp_s;
   logic [1:0]       sw_s;

   assign stp_s = stp_sync_q[1];
   assign sw_s  = sw_sync2_q;

   // State register: FSM, debounce counter, datapath registers, synchronizers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cur_s_q    <= '0;
         cur_a_q    <= '0;
         steps_q    <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         stp_sync_q <= '0;
         sw_sync1_q <= '0;
         sw_sync2_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_s_q    <= cur_s_d;
         cur_a_q    <= cur_a_d;
         steps_q    <= steps_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         stp_sync_q <= {stp_sync_q[0], Step_btn};
         sw_sync1_q <= Sw;
         sw_sync2_q <= sw_sync1_q;
      end
   end

   // Next-state logic: debounce press, apply one step, debounce release.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_s_d = cur_s_q;
      cur_a_d = cur_a_q;
      steps_d = steps_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (stp_s) begin
               state_d = ST_DEBOUNCE;
               cnt_d   = '0;
            end
         end
         ST_DEBOUNCE: begin
            if (!stp_s) begin
               // Glitch: drop back without touching any visible state.
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_APPLY;
               cnt_d   = '0;
               cur_a_d = sw_s;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_APPLY: begin
            // Out-of-range next states are replaced by 0 and flagged.
            if (Next_S <= S_MAX) begin
               cur_s_d = Next_S;
            end else begin
               cur_s_d = '0;
               err_d   = 1'b1;
            end
            if (steps_q != CNT_SAT) begin
               steps_d = steps_q + 1'b1;
            end
            state_d = ST_WAIT_REL;
            cnt_d   = '0;
         end
         ST_WAIT_REL: begin
            // Any high sample restarts the release window, so a held or
            // bouncing button never yields a second step.
            if (stp_s) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Output logic: all outputs come straight from registers.
   always_comb begin
      Cur_S      = cur_s_q;
      Cur_A      = cur_a_q;
      Busy       = busy_q;
      Step_count = steps_q;
      Err        = err_q;
   end

`ifdef STEP_SEVEN_SEG_EN
   logic [6:0] seg_q;

   // Active-low {g,f,e,d,c,b,a} patterns for digits 0..8; blank otherwise.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b1000000;
         4'd1:    p = 7'b1111001;
         4'd2:    p = 7'b0100100;
         4'd3:    p = 7'b0110000;
         4'd4:    p = 7'b0011001;
         4'd5:    p = 7'b0010010;
         4'd6:    p = 7'b0000010;
         4'd7:    p = 7'b1111000;
         4'd8:    p = 7'b0000000;
         default: p = 7'b1111111;
      endcase
      return p;
   endfunction

   // Registered segment decode, trailing Cur_S by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q <= 7'b1000000;
      end else begin
         seg_q <= seg_decode(cur_s_q);
      end
   end

   // Segment output drive.
   always_comb begin
      Seg = seg_q;
   end
`endif

endmodule

// File: tb/tb_step_state_register.sv
// tb_step_state_register: table-driven vectors, hand-written multi-cycle
// sequences and a randomized press stream checked against a transaction-level
// model. The bench also plays the NextStateLogic block.
module tb_step_state_register;

   localparam int D = 4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic       Step_btn;
   logic [1:0] Sw;
   logic [3:0] Next_S;
   logic [3:0] Cur_S;
   logic [1:0] Cur_A;
   logic       Busy;
   logic [7:0] Step_count;
   logic       Err;
`ifdef STEP_SEVEN_SEG_EN
   logic [6:0] Seg;
`endif
   logic       force_bad;

   always #5 clk = ~clk;

   step_state_register #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .Step_btn   (Step_btn),
      .Sw         (Sw),
      .Next_S     (Next_S),
      .Cur_S      (Cur_S),
      .Cur_A      (Cur_A),
      .Busy       (Busy),
      .Step_count (Step_count),
      .Err        (Err)
`ifdef STEP_SEVEN_SEG_EN
      ,
      .Seg        (Seg)
`endif
   );

   // NextStateLogic stand-in: 00 -> 0, 01 -> +1, 10 -> -1, 11 -> +4 (mod 9).
   function automatic logic [3:0] nsl(input logic [3:0] s, input logic [1:0] a);
      int v;
      v = int'(s);
      case (a)
         2'b00:   v = 0;
         2'b01:   v = (v + 1) % 9;
         2'b10:   v = (v + 8) % 9;
         default: v = (v + 4) % 9;
      endcase
      return 4'(v);
   endfunction

   always_comb Next_S = force_bad ? 4'hC : nsl(Cur_S, Cur_A);

`ifdef STEP_SEVEN_SEG_EN
   function automatic logic [6:0] seg_ref(input logic [3:0] d);
      logic [6:0] tbl [0:8];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
      return tbl[d];
   endfunction
`endif

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [14:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_all(input string tag, input logic [3:0] s, input logic [1:0] a,
                            input logic [7:0] cnt, input logic err);
      check($sformatf("%s.cur_s", tag), 32'(Cur_S), 32'(s));
      check($sformatf("%s.cur_a", tag), 32'(Cur_A), 32'(a));
      check($sformatf("%s.count", tag), 32'(Step_count), 32'(cnt));
      check($sformatf("%s.err", tag), 32'(Err), 32'(err));
      check($sformatf("%s.busy", tag), 32'(Busy), 32'(0));
`ifdef STEP_SEVEN_SEG_EN
      check($sformatf("%s.seg", tag), 32'(Seg), 32'(seg_ref(s)));
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1; Step_btn = 1'b0; Sw = 2'b00; force_bad = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
   endtask

   // One full press: settle Sw, hold the button len cycles, then idle long
   // enough for the release window to finish.
   task automatic do_press(input int len, input logic [1:0] sw, input logic bad);
      force_bad = bad;
      Sw = sw;
      repeat (3) tick();
      Step_btn = 1'b1;
      repeat (len) tick();
      Step_btn = 1'b0;
      repeat (D + 8) tick();
      force_bad = 1'b0;
   endtask

   // ---------------- reference model (per press) ----------------
   logic [3:0] m_s;
   logic [1:0] m_a;
   int         m_cnt;
   logic       m_err;

   task automatic model_press(input int len, input logic [1:0] sw, input logic bad);
      // A press counts once the synchronized level is seen D+1 times in a row.
      if (len >= D + 1) begin
         m_a = sw;
         if (bad) begin
            m_s = 4'd0;
            m_err = 1'b1;
         end else begin
            m_s = nsl(m_s, sw);
         end
         if (m_cnt < 255) m_cnt++;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int         len;
      logic [1:0] sw;
      logic       bad;
      logic [3:0] exp_s;
      logic [1:0] exp_a;
      logic [7:0] exp_cnt;
      logic       exp_err;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [14:0] e;
      // Starting point for the table: Cur_S=4, Cur_A=11, Step_count=1.
      vecs[0] = '{6, 2'b11, 1'b0, 4'd8, 2'b11, 8'd2, 1'b0};
      vecs[1] = '{6, 2'b00, 1'b0, 4'd0, 2'b00, 8'd3, 1'b0};
      vecs[2] = '{2, 2'b01, 1'b0, 4'd0, 2'b00, 8'd3, 1'b0};
      vecs[3] = '{D, 2'b01, 1'b0, 4'd0, 2'b00, 8'd3, 1'b0};
      vecs[4] = '{D + 1, 2'b01, 1'b0, 4'd1, 2'b01, 8'd4, 1'b0};
      vecs[5] = '{D + 1, 2'b10, 1'b0, 4'd0, 2'b10, 8'd5, 1'b0};
      vecs[6] = '{6, 2'b10, 1'b0, 4'd8, 2'b10, 8'd6, 1'b0};
      vecs[7] = '{6, 2'b01, 1'b1, 4'd0, 2'b01, 8'd7, 1'b1};
      vecs[8] = '{6, 2'b11, 1'b0, 4'd4, 2'b11, 8'd8, 1'b1};
      vecs[9] = '{3, 2'b00, 1'b0, 4'd4, 2'b11, 8'd8, 1'b1};

      reset_dut();
      check_all("reset", 4'd0, 2'b00, 8'd0, 1'b0);

      // First-press latency: edge 1 samples the button, Cur_S moves at edge D+4.
      Sw = 2'b11;
      repeat (3) tick();
      Step_btn = 1'b1;
      repeat (2) tick();
      check("lat.busy_e2", 32'(Busy), 32'(0));
      tick();
      check("lat.busy_e3", 32'(Busy), 32'(1));
      repeat (D) tick();
      check("lat.s_before", 32'(Cur_S), 32'(0));
      check("lat.a_latched", 32'(Cur_A), 32'(2'b11));
      tick();
      check("lat.s_after", 32'(Cur_S), 32'(4));
      check("lat.count", 32'(Step_count), 32'(1));
      check("lat.busy_hold", 32'(Busy), 32'(1));
      Step_btn = 1'b0;
      repeat (D + 8) tick();
      check_all("lat.end", 4'd4, 2'b11, 8'd1, 1'b0);

      // Table of press transactions.
      foreach (vecs[i]) begin
         do_press(vecs[i].len, vecs[i].sw, vecs[i].bad);
         check_all($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_a,
                   vecs[i].exp_cnt, vecs[i].exp_err);
      end

      // Err survives good steps, clears only on reset.
      reset_dut();
      check_all("err_clear", 4'd0, 2'b00, 8'd0, 1'b0);

      // Long hold with a Sw change mid-hold, then a bouncing release.
      Sw = 2'b01;
      repeat (3) tick();
      Step_btn = 1'b1;
      repeat (50) tick();
      Sw = 2'b10;
      repeat (50) tick();
      check("hold.busy", 32'(Busy), 32'(1));
      check("hold.count", 32'(Step_count), 32'(1));
      Step_btn = 1'b0; repeat (2) tick();
      Step_btn = 1'b1; tick();
      Step_btn = 1'b0; repeat (2) tick();
      Step_btn = 1'b1; tick();
      Step_btn = 1'b0;
      repeat (D + 1) tick();
      check("bounce.busy_still", 32'(Busy), 32'(1));
      tick();
      check("bounce.idle", 32'(Busy), 32'(0));
      repeat (4) tick();
      check_all("hold.end", 4'd1, 2'b01, 8'd1, 1'b0);

      // Reset landing on the APPLY exit edge wins over the update.
      Sw = 2'b01;
      repeat (3) tick();
      Step_btn = 1'b1;
      repeat (D + 3) tick();
      check("rst_apply.busy", 32'(Busy), 32'(1));
      check("rst_apply.s_pre", 32'(Cur_S), 32'(1));
      reset = 1'b1;
      Step_btn = 1'b0;
      tick();
      check_all("rst_apply", 4'd0, 2'b00, 8'd0, 1'b0);
      reset = 1'b0;
      repeat (D + 8) tick();
      check_all("rst_apply.after", 4'd0, 2'b00, 8'd0, 1'b0);

      // Saturation: 256 accepted steps, counter holds at 255.
      for (int i = 0; i < 256; i++) begin
         do_press(D + 1, 2'b01, 1'b0);
         if (i == 253) check("sat.254", 32'(Step_count), 32'(254));
         if (i == 254) check("sat.255", 32'(Step_count), 32'(255));
      end
      check_all("sat.end", 4'(256 % 9), 2'b01, 8'd255, 1'b0);

      // Randomized press stream against the model.
      reset_dut();
      m_s = 4'd0; m_a = 2'b00; m_cnt = 0; m_err = 1'b0;
      for (int i = 0; i < 40; i++) begin
         int         len;
         logic [1:0] sw;
         logic       bad;
         len = int'($urandom_range(1, 2 * D + 2));
         sw  = 2'($urandom_range(0, 3));
         bad = ($urandom_range(0, 9) == 0);
         model_press(len, sw, bad);
         exp_q.push_back({m_s, m_a, 8'(m_cnt), m_err});
         do_press(len, sw, bad);
         e = exp_q.pop_front();
         check_all($sformatf("rnd%0d", i), e[14:11], e[10:9], e[8:1], e[0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
